// File: rtl/axi_mst_if_pkg.sv
// ---------------------------------------------------------------------------
// axi_mst_if_pkg
// Purpose : shared types and widths for the AXI initiator (axi_mst_if) and
//           its bus interface (axi_mst_if_if).
// Contents: FSM state encoding, AXI response/burst codes, field widths and
//           the latched request payload.
// ---------------------------------------------------------------------------
package axi_mst_if_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;
    localparam int unsigned BRESP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } state_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    // Request fields captured on acceptance and held for the whole transaction.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
    } req_t;

endpackage

// File: rtl/axi_mst_if_if.sv
// ---------------------------------------------------------------------------
// axi_mst_if_if
// Purpose : AXI AR/R/AW/W/B bundle between the initiator and a responder.
//           Names and widths match the responder blocks port-for-port.
// Modports: master - initiator side (drives AR/AW/W payloads, rready, bready)
//           slave  - responder side (drives ready signals, R and B payloads)
// ---------------------------------------------------------------------------
interface axi_mst_if_if;
    import axi_mst_if_pkg::*;

    logic [ADDR_W-1:0]  araddr;
    logic               arvalid;
    logic               arready;
    logic [ID_W-1:0]    arid;
    logic [BURST_W-1:0] arbrust;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;

    logic [DATA_W-1:0]  rdata;
    logic               rvalid;
    logic               rready;
    logic [ID_W-1:0]    rid;
    logic               rlast;
    logic [RESP_W-1:0]  rresp;

    logic [ADDR_W-1:0]  awaddr;
    logic               awvalid;
    logic               awready;
    logic [ID_W-1:0]    awid;
    logic [BURST_W-1:0] awbrust;
    logic [LEN_W-1:0]   awlen;
    logic [SIZE_W-1:0]  awsize;

    logic [DATA_W-1:0]  wdata;
    logic               wvalid;
    logic               wready;
    logic               wlast;
    logic [STRB_W-1:0]  wstrb;

    logic               bready;
    logic               bvalid;
    logic [BRESP_W-1:0] bresp;
    logic [ID_W-1:0]    bid;

    modport master (
        output araddr, arvalid, arid, arbrust, arlen, arsize,
        input  arready,
        input  rdata, rvalid, rid, rlast, rresp,
        output rready,
        output awaddr, awvalid, awid, awbrust, awlen, awsize,
        input  awready,
        output wdata, wvalid, wlast, wstrb,
        input  wready,
        output bready,
        input  bvalid, bresp, bid
    );

    modport slave (
        input  araddr, arvalid, arid, arbrust, arlen, arsize,
        output arready,
        output rdata, rvalid, rid, rlast, rresp,
        input  rready,
        input  awaddr, awvalid, awid, awbrust, awlen, awsize,
        output awready,
        input  wdata, wvalid, wlast, wstrb,
        output wready,
        input  bready,
        output bvalid, bresp, bid
    );

endinterface

// File: rtl/axi_mst_if.sv
// ---------------------------------------------------------------------------
// axi_mst_if
// Purpose : AXI initiator turning a single-request core port into AR/R or
//           AW/W/B INCR bursts (1..256 beats, 32-bit data), one transaction
//           outstanding at a time.
// Ports   : clk, rst            - clock, async active-high reset
//           i_req_* / o_req_ready - request (write flag, addr, len-1, size)
//           o_rd_* / i_rd_ready - read beats, zero-latency pass-through of R
//           i_wr_* / o_wr_ready - write beats, zero-latency pass-through to W
//           o_done / o_err      - one-cycle completion pulse and status
//           m_axi               - AXI bus (master modport)
// ---------------------------------------------------------------------------
module axi_mst_if
    import axi_mst_if_pkg::*;
#(
    parameter logic [ID_W-1:0]    ID    = 4'd0,
    parameter logic [BURST_W-1:0] BURST = 2'b01
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_write,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [LEN_W-1:0]    i_req_len,
    input  logic [SIZE_W-1:0]   i_req_size,

    output logic [DATA_W-1:0]   o_rd_data,
    output logic                o_rd_valid,
    input  logic                i_rd_ready,
    output logic                o_rd_last,

    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic [STRB_W-1:0]   i_wr_strb,
    input  logic                i_wr_valid,
    output logic                o_wr_ready,

    output logic                o_done,
    output logic                o_err,

    axi_mst_if_if.master        m_axi
);

    state_e            r_state;
    req_t              r_req;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_flag;
    logic              r_req_ready;
    logic              r_arvalid;
    logic              r_awvalid;
    logic              r_bready;
    logic              r_done;
    logic              r_err;

    logic              w_in_r;
    logic              w_in_w;
    logic              w_cnt_last;
    logic              w_r_hs;
    logic              w_w_hs;
    logic              w_r_beat_err;
    logic              w_b_err;
    logic              w_unused;

    assign w_in_r     = (r_state == ST_R);
    assign w_in_w     = (r_state == ST_W);
    assign w_cnt_last = (r_cnt == r_req.len);
    assign w_r_hs     = w_in_r & m_axi.rvalid & i_rd_ready;
    assign w_w_hs     = w_in_w & i_wr_valid & m_axi.wready;

    // A read beat is bad on a non-OKAY response, a foreign ID, or an rlast
    // that does not line up with the requested length.
    assign w_r_beat_err = (m_axi.rresp != RESP_W'(RESP_OKAY))
                        | (m_axi.rid != ID)
                        | (m_axi.rlast != w_cnt_last);
    assign w_b_err      = (m_axi.bresp[RESP_W-1:0] != RESP_W'(RESP_OKAY))
                        | (m_axi.bid != ID);

    // Upper bresp bits carry no meaning for this initiator.
    assign w_unused = ^m_axi.bresp[BRESP_W-1:RESP_W];

    // Address channels present the latched request.
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.araddr  = r_req.addr;
    assign m_axi.arlen   = r_req.len;
    assign m_axi.arsize  = r_req.size;
    assign m_axi.arid    = ID;
    assign m_axi.arbrust = BURST;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.awaddr  = r_req.addr;
    assign m_axi.awlen   = r_req.len;
    assign m_axi.awsize  = r_req.size;
    assign m_axi.awid    = ID;
    assign m_axi.awbrust = BURST;

    // Data beats pass straight through, gated by the state so nothing leaks
    // outside the R/W phases (and everything drops with async reset).
    assign m_axi.rready = w_in_r & i_rd_ready;
    assign o_rd_valid   = w_in_r & m_axi.rvalid;
    assign o_rd_data    = m_axi.rdata;
    assign o_rd_last    = w_in_r & m_axi.rlast;

    assign m_axi.wvalid = w_in_w & i_wr_valid;
    assign m_axi.wdata  = i_wr_data;
    assign m_axi.wstrb  = i_wr_strb;
    assign m_axi.wlast  = w_in_w & w_cnt_last;
    assign o_wr_ready   = w_in_w & m_axi.wready;

    assign m_axi.bready = r_bready;
    assign o_req_ready  = r_req_ready;
    assign o_done       = r_done;
    assign o_err        = r_err;

    // Transaction FSM; shared beat counter and sticky error flag serve R and W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_cnt       <= '0;
            r_flag      <= 1'b0;
            r_req_ready <= 1'b0;
            r_arvalid   <= 1'b0;
            r_awvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (i_req_valid && r_req_ready) begin
                        r_req       <= '{write: i_req_write, addr: i_req_addr,
                                         len: i_req_len, size: i_req_size};
                        r_cnt       <= '0;
                        r_flag      <= 1'b0;
                        r_req_ready <= 1'b0;
                        if (i_req_write) begin
                            r_awvalid <= 1'b1;
                            r_state   <= ST_AW;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (m_axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (w_r_hs) begin
                        r_cnt  <= r_cnt + LEN_W'(1);
                        r_flag <= r_flag | w_r_beat_err;
                        // An early rlast still ends the burst (flagged above).
                        if (m_axi.rlast || w_cnt_last) begin
                            r_done      <= 1'b1;
                            r_err       <= r_flag | w_r_beat_err;
                            r_req_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                ST_AW: begin
                    if (m_axi.awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_w_hs) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_cnt_last) begin
                            r_bready <= 1'b1;
                            r_state  <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (m_axi.bvalid) begin
                        r_bready    <= 1'b0;
                        r_flag      <= r_flag | w_b_err;
                        r_done      <= 1'b1;
                        r_err       <= r_flag | w_b_err;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mst_if.sv
// ---------------------------------------------------------------------------
// tb_axi_mst_if
// Purpose : self-checking bench for axi_mst_if. A table of transactions is
//           played through a scripted responder; read/write beats and
//           completions are checked against scoreboard queues, plus
//           hand-written reset-mid-burst and back-to-back sequences.
// ---------------------------------------------------------------------------
module tb_axi_mst_if;
    import axi_mst_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_write;
    logic [63:0] i_req_addr;
    logic [7:0]  i_req_len;
    logic [2:0]  i_req_size;
    logic        o_req_ready;
    logic [31:0] o_rd_data;
    logic        o_rd_valid, o_rd_last, i_rd_ready;
    logic [31:0] i_wr_data;
    logic [3:0]  i_wr_strb;
    logic        i_wr_valid, o_wr_ready;
    logic        o_done, o_err;

    axi_mst_if_if bus();

    axi_mst_if #(.ID(4'd0), .BURST(2'b01)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_write (i_req_write),
        .i_req_addr  (i_req_addr),
        .i_req_len   (i_req_len),
        .i_req_size  (i_req_size),
        .o_rd_data   (o_rd_data),
        .o_rd_valid  (o_rd_valid),
        .i_rd_ready  (i_rd_ready),
        .o_rd_last   (o_rd_last),
        .i_wr_data   (i_wr_data),
        .i_wr_strb   (i_wr_strb),
        .i_wr_valid  (i_wr_valid),
        .o_wr_ready  (o_wr_ready),
        .o_done      (o_done),
        .o_err       (o_err),
        .m_axi       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          write;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        int          dly;      // cycles arready/awready is withheld
        logic [1:0]  resp;     // rresp on every beat, or bresp
        logic [3:0]  id;       // rid or bid returned
        int          last_at;  // read beat carrying rlast
        bit          toggle;   // read: rd_ready 1,0,1,0 / write: gapped wr_valid
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    beat_t  exp_r[$];
    beat_t  exp_w[$];
    logic   exp_done[$];
    beat_t  mon_b;
    logic   mon_e;
    vec_t   vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: compare beats and completions as the DUT produces them.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rvalid)
                chk("rready_mirror", 64'(bus.rready), 64'(i_rd_ready));
            if (bus.rvalid && bus.rready) begin
                chk("rd_expected", 64'(exp_r.size() > 0), 64'd1);
                if (exp_r.size() > 0) begin
                    mon_b = exp_r.pop_front();
                    chk("rd_valid", 64'(o_rd_valid), 64'd1);
                    chk("rd_data",  64'(o_rd_data),  64'(mon_b.data));
                    chk("rd_last",  64'(o_rd_last),  64'(mon_b.last));
                end
            end
            if (bus.wvalid && bus.wready) begin
                chk("w_expected", 64'(exp_w.size() > 0), 64'd1);
                if (exp_w.size() > 0) begin
                    mon_b = exp_w.pop_front();
                    chk("wr_ready", 64'(o_wr_ready),   64'd1);
                    chk("wdata",    64'(bus.wdata),    64'(mon_b.data));
                    chk("wstrb",    64'(bus.wstrb),    64'(mon_b.strb));
                    chk("wlast",    64'(bus.wlast),    64'(mon_b.last));
                end
            end
            if (o_done) begin
                chk("done_expected", 64'(exp_done.size() > 0), 64'd1);
                if (exp_done.size() > 0) begin
                    mon_e = exp_done.pop_front();
                    chk("done_err",       64'(o_err),       64'(mon_e));
                    chk("done_req_ready", 64'(o_req_ready), 64'd1);
                end
            end
        end
    end

    task automatic req_issue(input bit w, input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input bit keep);
        int k = 0;
        i_req_valid = 1'b1;
        i_req_write = w;
        i_req_addr  = addr;
        i_req_len   = len;
        i_req_size  = size;
        @(negedge clk);
        while (!o_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready", 64'(o_req_ready), 64'd1);
        @(posedge clk); #1;
        if (!keep) i_req_valid = 1'b0;
    endtask

    task automatic ar_phase(input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input int dly);
        int k = 0;
        @(negedge clk);
        while (!bus.arvalid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("arvalid", 64'(bus.arvalid), 64'd1);
        chk("araddr",  bus.araddr,       addr);
        chk("arlen",   64'(bus.arlen),   64'(len));
        chk("arsize",  64'(bus.arsize),  64'(size));
        chk("arid",    64'(bus.arid),    64'd0);
        chk("arburst", 64'(bus.arbrust), 64'd1);
        @(posedge clk); #1;
        repeat (dly) begin
            @(posedge clk); #1;
        end
        chk("arvalid_hold", 64'(bus.arvalid), 64'd1);
        bus.arready = 1'b1;
        @(posedge clk); #1;
        bus.arready = 1'b0;
    endtask

    task automatic r_phase(input logic [7:0] len, input int last_at, input logic [1:0] resp,
                           input logic [3:0] id, input bit toggle);
        int    nb = (last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
        beat_t e;
        bit    hs;
        int    k;
        i_rd_ready = 1'b1;
        for (int b = 0; b < nb; b++) begin
            e.data = $urandom;
            e.strb = 4'h0;
            e.last = (b == last_at);
            bus.rvalid = 1'b1;
            bus.rdata  = e.data;
            bus.rlast  = e.last;
            bus.rresp  = resp;
            bus.rid    = id;
            exp_r.push_back(e);
            hs = 1'b0;
            k  = 0;
            while (!hs && k < 20) begin
                @(negedge clk);
                hs = bus.rready;
                @(posedge clk); #1;
                if (toggle) i_rd_ready = ~i_rd_ready;
                k++;
            end
            if (!hs) begin
                chk("r_handshake", 64'(hs), 64'd1);
                break;
            end
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        i_rd_ready = 1'b1;
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_done.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (exp_done.size() != 0) begin
            chk("done_pending", 64'(exp_done.size()), 64'd0);
            exp_done.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run_read(input vec_t v);
        exp_done.push_back(v.exp_err);
        req_issue(1'b0, v.addr, v.len, v.size, 1'b0);
        ar_phase(v.addr, v.len, v.size, v.dly);
        r_phase(v.len, v.last_at, v.resp, v.id, v.toggle);
        wait_done();
    endtask

    task automatic run_write(input vec_t v);
        int    k = 0;
        bit    hs;
        beat_t e;
        exp_done.push_back(v.exp_err);
        bus.wready = 1'b1;
        req_issue(1'b1, v.addr, v.len, v.size, 1'b0);
        @(negedge clk);
        while (!bus.awvalid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("awvalid", 64'(bus.awvalid), 64'd1);
        chk("awaddr",  bus.awaddr,       v.addr);
        chk("awlen",   64'(bus.awlen),   64'(v.len));
        chk("awsize",  64'(bus.awsize),  64'(v.size));
        chk("awid",    64'(bus.awid),    64'd0);
        chk("awburst", 64'(bus.awbrust), 64'd1);
        @(posedge clk); #1;
        // First beat is offered while AW is still pending; it must be held back.
        for (int b = 0; b <= int'(v.len); b++) begin
            if (b > 0 && v.toggle) begin
                i_wr_valid = 1'b0;
                @(negedge clk);
                chk("w_gap", 64'(bus.wvalid), 64'd0);
                @(posedge clk); #1;
            end
            e.data = 32'(32'h11 * (b + 1));
            e.strb = 4'hF;
            e.last = (b == int'(v.len));
            i_wr_valid = 1'b1;
            i_wr_data  = e.data;
            i_wr_strb  = e.strb;
            exp_w.push_back(e);
            if (b == 0) begin
                repeat (v.dly) begin
                    @(negedge clk);
                    chk("no_w_before_aw", 64'(bus.wvalid), 64'd0);
                    @(posedge clk); #1;
                end
                bus.awready = 1'b1;
                @(negedge clk);
                chk("no_w_during_aw_hs", 64'(bus.wvalid), 64'd0);
                @(posedge clk); #1;
                bus.awready = 1'b0;
            end
            hs = 1'b0;
            k  = 0;
            while (!hs && k < 20) begin
                @(negedge clk);
                hs = bus.wvalid && bus.wready;
                @(posedge clk); #1;
                k++;
            end
            if (!hs) begin
                chk("w_handshake", 64'(hs), 64'd1);
                break;
            end
        end
        i_wr_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!bus.bready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bready", 64'(bus.bready), 64'd1);
        @(posedge clk); #1;
        bus.bvalid = 1'b1;
        bus.bresp  = {2'b00, v.resp};
        bus.bid    = v.id;
        @(posedge clk); #1;
        bus.bvalid = 1'b0;
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        beat_t       e;
        logic [63:0] a2;
        //          wr    addr                    len     size  dly resp   id    last tog err
        vecs[0] = '{1'b0, 64'h0000_0000_8000_0000, 8'd0,   3'd2, 2, 2'd0, 4'h0, 0,   1'b0, 1'b0};
        vecs[1] = '{1'b0, 64'h0000_0000_0000_1000, 8'd3,   3'd2, 0, 2'd0, 4'h0, 3,   1'b1, 1'b0};
        vecs[2] = '{1'b1, 64'h0000_0000_0000_2000, 8'd1,   3'd2, 3, 2'd0, 4'h0, 0,   1'b1, 1'b0};
        vecs[3] = '{1'b0, 64'h0000_0000_0000_3000, 8'd0,   3'd2, 1, 2'd2, 4'h0, 0,   1'b0, 1'b1};
        vecs[4] = '{1'b0, 64'h0000_0000_0000_4000, 8'd2,   3'd2, 0, 2'd0, 4'h0, 0,   1'b0, 1'b1};
        vecs[5] = '{1'b1, 64'h0000_0000_0000_5000, 8'd0,   3'd2, 0, 2'd0, 4'h5, 0,   1'b0, 1'b1};
        vecs[6] = '{1'b0, 64'hFFFF_0000_0000_1000, 8'd255, 3'd2, 1, 2'd0, 4'h0, 255, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 64'h0000_0000_0000_7000, 8'd3,   3'd1, 0, 2'd3, 4'h0, 0,   1'b0, 1'b1};
        vecs[8] = '{1'b1, 64'h0000_0000_0000_9000, 8'd2,   3'd2, 1, 2'd0, 4'h0, 0,   1'b0, 1'b0};
        vecs[9] = '{1'b0, 64'h0000_0000_0000_A000, 8'd1,   3'd2, 0, 2'd0, 4'h3, 1,   1'b0, 1'b1};

        rst = 1'b1;
        i_req_valid = 1'b0; i_req_write = 1'b0; i_req_addr = '0; i_req_len = '0; i_req_size = '0;
        i_rd_ready = 1'b1; i_wr_data = '0; i_wr_strb = '0; i_wr_valid = 1'b0;
        bus.arready = 1'b0; bus.rdata = '0; bus.rvalid = 1'b0; bus.rid = '0; bus.rlast = 1'b0;
        bus.rresp = '0; bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        bus.bresp = '0; bus.bid = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(o_req_ready), 64'd0);
        chk("rst_arvalid",   64'(bus.arvalid), 64'd0);
        chk("rst_awvalid",   64'(bus.awvalid), 64'd0);
        chk("rst_wvalid",    64'(bus.wvalid),  64'd0);
        chk("rst_wlast",     64'(bus.wlast),   64'd0);
        chk("rst_rready",    64'(bus.rready),  64'd0);
        chk("rst_bready",    64'(bus.bready),  64'd0);
        chk("rst_rd_valid",  64'(o_rd_valid),  64'd0);
        chk("rst_wr_ready",  64'(o_wr_ready),  64'd0);
        chk("rst_done",      64'(o_done),      64'd0);
        chk("rst_err",       64'(o_err),       64'd0);
        chk("rst_araddr",    bus.araddr,       64'd0);
        chk("rst_arlen",     64'(bus.arlen),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].write) run_write(vecs[i]);
            else               run_read(vecs[i]);
        end

        // Reset asserted between read beats of a len-3 burst.
        req_issue(1'b0, 64'h6000, 8'd3, 3'd2, 1'b0);
        ar_phase(64'h6000, 8'd3, 3'd2, 0);
        e.data = 32'hCAFE_0001; e.strb = 4'h0; e.last = 1'b0;
        bus.rvalid = 1'b1; bus.rdata = e.data; bus.rlast = 1'b0; bus.rresp = 2'd0; bus.rid = 4'h0;
        exp_r.push_back(e);
        @(negedge clk);
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        @(negedge clk);
        chk("rready_pre_rst", 64'(bus.rready), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_rready",  64'(bus.rready),  64'd0);
        chk("rst_async_arvalid", 64'(bus.arvalid), 64'd0);
        chk("rst_async_done",    64'(o_done),      64'd0);
        chk("rst_async_reqrdy",  64'(o_req_ready), 64'd0);
        exp_r.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("req_ready_post_rst", 64'(o_req_ready), 64'd1);
        v = '{1'b0, 64'h0000_0000_0000_6100, 8'd1, 3'd2, 1, 2'd0, 4'h0, 1, 1'b0, 1'b0};
        run_read(v);

        // Back-to-back reads with req_valid held high.
        a2 = 64'h0000_0000_0000_B200;
        exp_done.push_back(1'b0);
        req_issue(1'b0, 64'h0000_0000_0000_B100, 8'd0, 3'd2, 1'b1);
        i_req_addr = a2;
        ar_phase(64'h0000_0000_0000_B100, 8'd0, 3'd2, 0);
        r_phase(8'd0, 0, 2'd0, 4'h0, 1'b0);
        exp_done.push_back(1'b0);
        @(negedge clk);
        chk("b2b_done",      64'(o_done),      64'd1);
        chk("b2b_req_ready", 64'(o_req_ready), 64'd1);
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_arvalid", 64'(bus.arvalid), 64'd1);
        chk("b2b_araddr",  bus.araddr,       a2);
        ar_phase(a2, 8'd0, 3'd2, 0);
        r_phase(8'd0, 0, 2'd0, 4'h0, 1'b0);
        wait_done();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
